// File: rtl/rsa_frame_ctrl.sv
// rsa_frame_ctrl: byte-serial front end for the modexp engine.
// Loads base/exponent/modulus, starts the engine, streams C back out.
module rsa_frame_ctrl #(
   parameter int W       = 64,
   parameter int TIMEOUT = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] base,
   output logic [W-1:0] exponent,
   output logic [W-1:0] modulus,
   output logic         done,
   input  logic [W-1:0] C,
   input  logic         done_encrypt,
   output logic [7:0]   out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         err
);

   localparam int NB  = W / 8;
   localparam int BCW = $clog2(3 * NB);
   localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [BCW-1:0] B_ONE    = BCW'(1);
   localparam logic [BCW-1:0] EXP_LO   = BCW'(NB);
   localparam logic [BCW-1:0] MOD_LO   = BCW'(2 * NB);
   localparam logic [BCW-1:0] LAST_IN  = BCW'(3 * NB - 1);
   localparam logic [BCW-1:0] LAST_OUT = BCW'(NB - 1);
   localparam logic [TCW-1:0] T_ONE    = TCW'(1);
   localparam logic [TCW-1:0] T_LAST   = TCW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_START,
      S_WAIT,
      S_SEND,
      S_ERR
   } state_t;

   state_t         r_state;
   state_t         w_nxt;
   logic [BCW-1:0] r_bcnt;
   logic [TCW-1:0] r_tcnt;
   logic [W-1:0]   r_base;
   logic [W-1:0]   r_exp;
   logic [W-1:0]   r_mod;
   logic [W-1:0]   r_res;
   logic           r_err;

   logic           w_in_acc;
   logic           w_in_last;
   logic           w_tx_hs;
   logic [W-1:0]   w_base_sh;
   logic [W-1:0]   w_exp_sh;
   logic [W-1:0]   w_mod_sh;
   logic           w_mod_zero;

   // Append one byte at the LSB end of an operand (MSB-first load).
   function automatic logic [W-1:0] shift_in(
      input logic [W-1:0] v,
      input logic [7:0]   b
   );
      logic [W+7:0] t;
      t = {v, b};
      return t[W-1:0];
   endfunction

   // Handshake strobes and shifted operand candidates.
   always_comb begin
      w_in_acc   = (r_state == S_LOAD) && in_valid;
      w_in_last  = w_in_acc && (r_bcnt == LAST_IN);
      w_tx_hs    = (r_state == S_SEND) && out_ready;
      w_base_sh  = shift_in(r_base, in_data);
      w_exp_sh   = shift_in(r_exp, in_data);
      w_mod_sh   = shift_in(r_mod, in_data);
      w_mod_zero = (w_mod_sh == '0);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_LOAD;
      else      r_state <= w_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_nxt     = r_state;
      in_ready  = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (r_state)
         S_LOAD: begin
            in_ready = 1'b1;
            if (w_in_last)
               w_nxt = w_mod_zero ? S_ERR : S_START;
         end
         S_START: begin
            done  = 1'b1;
            busy  = 1'b1;
            w_nxt = S_WAIT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (done_encrypt)
               w_nxt = S_SEND;
            else if (r_tcnt == T_LAST)
               w_nxt = S_ERR;
         end
         S_SEND: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (w_tx_hs && (r_bcnt == LAST_OUT))
               w_nxt = S_LOAD;
         end
         S_ERR: begin
            w_nxt = S_LOAD;
         end
         default: begin
            w_nxt = S_LOAD;
         end
      endcase
   end

   // Operand load, byte counter, timeout counter, result shifter, err.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bcnt <= '0;
         r_tcnt <= '0;
         r_base <= '0;
         r_exp  <= '0;
         r_mod  <= '0;
         r_res  <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_in_acc) begin
            if (r_bcnt == '0)
               r_err <= 1'b0;
            if (r_bcnt < EXP_LO)
               r_base <= w_base_sh;
            else if (r_bcnt < MOD_LO)
               r_exp <= w_exp_sh;
            else
               r_mod <= w_mod_sh;
            r_bcnt <= w_in_last ? '0 : r_bcnt + B_ONE;
         end
         if (r_state == S_START)
            r_tcnt <= '0;
         if (r_state == S_WAIT) begin
            if (done_encrypt)
               r_res <= C;
            else
               r_tcnt <= r_tcnt + T_ONE;
         end
         if (w_tx_hs) begin
            r_res  <= r_res << 8;
            r_bcnt <= (r_bcnt == LAST_OUT) ? '0 : r_bcnt + B_ONE;
         end
         if (w_nxt == S_ERR)
            r_err <= 1'b1;
      end
   end

   assign base     = r_base;
   assign exponent = r_exp;
   assign modulus  = r_mod;
   assign out_data = r_res[W-1:W-8];
   assign err      = r_err;

endmodule

// File: tb/tb_rsa_frame_ctrl.sv
// tb_rsa_frame_ctrl: directed checks of framing, engine handshake,
// zero-modulus and timeout errors, spurious inputs and async reset.
module tb_rsa_frame_ctrl;

   localparam logic [63:0] B  = 64'd4;
   localparam logic [63:0] E  = 64'd13;
   localparam logic [63:0] M  = 64'd497;
   localparam logic [63:0] R  = 64'd445;
   localparam logic [63:0] JK = 64'hA5A5_5A5A_DEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic [63:0] C;
   logic        done_encrypt;
   logic        out_ready;

   logic        in_ready, done, out_valid, busy, err;
   logic [63:0] base, exponent, modulus;
   logic [7:0]  out_data;

   logic        in_ready_t, done_t, out_valid_t, busy_t, err_t;
   logic [63:0] base_t, exponent_t, modulus_t;
   logic [7:0]  out_data_t;

   bit          use16;
   logic        m_inrdy, m_done, m_ovalid, m_busy, m_err;
   logic [7:0]  m_odata;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic        e0;

   always #5 clk = ~clk;

   rsa_frame_ctrl #(.W(64), .TIMEOUT(4096)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .base         (base),
      .exponent     (exponent),
      .modulus      (modulus),
      .done         (done),
      .C            (C),
      .done_encrypt (done_encrypt),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .err          (err)
   );

   rsa_frame_ctrl #(.W(64), .TIMEOUT(16)) u_dut16 (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready_t),
      .base         (base_t),
      .exponent     (exponent_t),
      .modulus      (modulus_t),
      .done         (done_t),
      .C            (C),
      .done_encrypt (done_encrypt),
      .out_data     (out_data_t),
      .out_valid    (out_valid_t),
      .out_ready    (out_ready),
      .busy         (busy_t),
      .err          (err_t)
   );

   assign m_inrdy  = use16 ? in_ready_t  : in_ready;
   assign m_done   = use16 ? done_t      : done;
   assign m_ovalid = use16 ? out_valid_t : out_valid;
   assign m_busy   = use16 ? busy_t      : busy;
   assign m_err    = use16 ? err_t       : err;
   assign m_odata  = use16 ? out_data_t  : out_data;

   task automatic chk_eq(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic send_frame(input logic [63:0] b, input logic [63:0] e,
                             input logic [63:0] m, input bit gaps,
                             output logic err0);
      logic [63:0] op;
      err0 = 1'b0;
      for (int i = 0; i < 24; i++) begin
         op       = (i < 8) ? b : (i < 16) ? e : m;
         in_data  = op[63-8*(i%8) -: 8];
         in_valid = 1'b1;
         if (i == 23) chk_eq("pre_done", m_done, 0);
         @(posedge clk); #1;
         if (i == 0) err0 = m_err;
         in_valid = 1'b0;
         if (gaps && i != 23) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic engine(input int lat, input logic [63:0] c);
      @(posedge clk); #1;
      chk_eq("done_1cyc", m_done, 0);
      chk_eq("wait_busy", m_busy, 1);
      repeat (lat - 1) begin
         @(posedge clk); #1;
      end
      C            = c;
      done_encrypt = 1'b1;
      @(posedge clk); #1;
      done_encrypt = 1'b0;
      C            = '0;
      chk_eq("send_valid", m_ovalid, 1);
   endtask

   task automatic recv(input logic [63:0] exp, input int n,
                       input int stall_at, input bit spur);
      logic [7:0] eb;
      out_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         eb = exp[63-8*k -: 8];
         chk_eq("oval", m_ovalid, 1);
         chk_eq("obyte", m_odata, eb);
         if (k == stall_at) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(posedge clk); #1;
            end
            chk_eq("stall_byte", m_odata, eb);
            chk_eq("stall_val", m_ovalid, 1);
            out_ready = 1'b1;
         end
         if (spur && k == 2) begin
            C            = JK;
            done_encrypt = 1'b1;
         end
         @(posedge clk); #1;
         done_encrypt = 1'b0;
         C            = '0;
      end
      out_ready = 1'b0;
   endtask

   task automatic end_chk();
      chk_eq("end_oval", m_ovalid, 0);
      chk_eq("end_busy", m_busy, 0);
      chk_eq("end_err", m_err, 0);
      chk_eq("end_inrdy", m_inrdy, 1);
   endtask

   task automatic do_reset(input bit chk);
      #2;
      rst = 1'b0;
      #1;
      if (chk) begin
         chk_eq("ar_inrdy", m_inrdy, 1);
         chk_eq("ar_done", m_done, 0);
         chk_eq("ar_oval", m_ovalid, 0);
         chk_eq("ar_busy", m_busy, 0);
         chk_eq("ar_odata", m_odata, 0);
         chk_eq("ar_err", m_err, 0);
         chk_eq("ar_base", base, 0);
         chk_eq("ar_mod", modulus, 0);
      end
      @(posedge clk); #3;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic full_ok(input bit gaps, input int stall_at, input bit spur);
      send_frame(B, E, M, gaps, e0);
      chk_eq("st_done", m_done, 1);
      engine(20, R);
      recv(R, 8, stall_at, spur);
      end_chk();
   endtask

   initial begin
      use16        = 1'b0;
      rst          = 1'b0;
      in_data      = '0;
      in_valid     = 1'b0;
      C            = '0;
      done_encrypt = 1'b0;
      out_ready    = 1'b0;
      #1;
      chk_eq("rst_inrdy", in_ready, 1);
      chk_eq("rst_done", done, 0);
      chk_eq("rst_oval", out_valid, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_err", err, 0);
      chk_eq("rst_exp", exponent, 0);
      @(posedge clk); #3;
      rst = 1'b1;
      @(posedge clk); #1;

      // basic frame
      send_frame(B, E, M, 1'b0, e0);
      chk_eq("t1_done", done, 1);
      chk_eq("t1_busy", busy, 1);
      chk_eq("t1_inrdy", in_ready, 0);
      chk_eq("t1_base", base, B);
      chk_eq("t1_exp", exponent, E);
      chk_eq("t1_mod", modulus, M);
      engine(20, R);
      chk_eq("t1_base_hold", base, B);
      recv(R, 8, -1, 1'b0);
      end_chk();

      // gapped input, stalled output
      send_frame(B, E, M, 1'b1, e0);
      chk_eq("t2_done", done, 1);
      chk_eq("t2_base", base, B);
      chk_eq("t2_exp", exponent, E);
      chk_eq("t2_mod", modulus, M);
      engine(20, R);
      recv(R, 8, 3, 1'b0);
      end_chk();

      // zero modulus
      send_frame(B, E, 64'd0, 1'b0, e0);
      chk_eq("t3_nodone", done, 0);
      chk_eq("t3_err", err, 1);
      chk_eq("t3_busy", busy, 0);
      @(posedge clk); #1;
      chk_eq("t3_err_hold", err, 1);
      chk_eq("t3_inrdy", in_ready, 1);
      chk_eq("t3_nodone2", done, 0);
      send_frame(B, E, M, 1'b0, e0);
      chk_eq("t3_err_clr", e0, 0);
      chk_eq("t3_done", done, 1);
      engine(20, R);
      recv(R, 8, -1, 1'b0);
      end_chk();

      // spurious done_encrypt in LOAD and SEND
      C            = JK;
      done_encrypt = 1'b1;
      @(posedge clk); #1;
      done_encrypt = 1'b0;
      C            = '0;
      chk_eq("t4_inrdy", in_ready, 1);
      chk_eq("t4_oval", out_valid, 0);
      chk_eq("t4_busy", busy, 0);
      full_ok(1'b0, -1, 1'b1);

      // async reset mid-WAIT, then a clean frame
      send_frame(B, E, M, 1'b0, e0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk_eq("t5_wait", busy, 1);
      do_reset(1'b1);
      full_ok(1'b0, -1, 1'b0);

      // async reset mid-SEND, then a clean frame
      send_frame(B, E, M, 1'b0, e0);
      engine(20, R);
      recv(R, 3, -1, 1'b0);
      chk_eq("t5_send", out_valid, 1);
      do_reset(1'b1);
      full_ok(1'b0, -1, 1'b0);

      // TIMEOUT=16 instance: engine never answers
      use16 = 1'b1;
      do_reset(1'b0);
      send_frame(B, E, M, 1'b0, e0);
      chk_eq("t6_done", done_t, 1);
      repeat (16) begin
         @(posedge clk); #1;
      end
      chk_eq("t6_w16_err", err_t, 0);
      chk_eq("t6_w16_busy", busy_t, 1);
      @(posedge clk); #1;
      chk_eq("t6_err", err_t, 1);
      chk_eq("t6_oval", out_valid_t, 0);
      chk_eq("t6_busy", busy_t, 0);
      @(posedge clk); #1;
      chk_eq("t6_err_hold", err_t, 1);
      chk_eq("t6_inrdy", in_ready_t, 1);

      // answer on the 16th WAIT cycle: capture wins
      send_frame(B, E, M, 1'b0, e0);
      chk_eq("t7_err_clr", e0, 0);
      chk_eq("t7_base", base_t, B);
      chk_eq("t7_exp", exponent_t, E);
      chk_eq("t7_mod", modulus_t, M);
      engine(16, R);
      chk_eq("t7_noerr", err_t, 0);
      recv(R, 8, -1, 1'b0);
      end_chk();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rsa_frame_ctrl.md
Name: rsa_frame_ctrl

Overview:
- Upstream/downstream controller for the 64-bit modular-exponentiation engine.
- Assembles a byte-serial request frame into base, exponent and modulus operands, then issues the one-cycle `done` start pulse to the engine.
- Waits for the engine's `done_encrypt`, captures the result `C`, and streams it back out byte-serially with valid/ready flow control.
- Also guards against a zero modulus and against an engine that never finishes.

Parameters:
- W, 64: operand/result width in bits; must be a multiple of 8. NB = W/8 bytes per operand.
- TIMEOUT, 4096: maximum cycles spent in WAIT before flagging an error; minimum 2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- in_data  input  8  request byte
- in_valid  input  1  in_data valid
- in_ready  output  1  request byte accepted when in_valid && in_ready
- base  output  W  operand to engine
- exponent  output  W  operand to engine
- modulus  output  W  operand to engine
- done  output  1  engine start pulse, exactly one cycle
- C  input  W  engine result
- done_encrypt  input  1  engine completion, sampled only in WAIT
- out_data  output  8  result byte
- out_valid  output  1  out_data valid
- out_ready  input  1  result byte consumed when out_valid && out_ready
- busy  output  1  high in START, WAIT and SEND
- err  output  1  sticky error flag

Behaviour:
- Reset:
  - Asynchronous and active-low; asserting rst at any time, including mid-frame, returns the block to LOAD.
  - On reset, all outputs are 0 except in_ready, which is 1 because the block is in LOAD.
  - Byte counter, timeout counter and result register are cleared on reset.
- States: LOAD, START, WAIT, SEND, ERR.
- LOAD:
  - in_ready=1.
  - Each accepted byte is shifted MSB-first into the selected operand register:
    - bytes 0..NB-1 go to base,
    - bytes NB..2NB-1 go to exponent,
    - bytes 2NB..3NB-1 go to modulus.
  - The byte counter is 0..3NB-1.
  - Gaps in in_valid are allowed.
  - Accepting byte 0 clears err.
  - When the last byte is accepted, the zero check is made on the modulus value that includes that byte:
    - modulus != 0: go to START next cycle.
    - modulus == 0: go to ERR.
  - The byte counter resets to 0 in both cases.
- START:
  - done=1 for exactly this one cycle; in_ready=0.
  - The cycle after the last byte is accepted is the done cycle (latency 1).
  - Next state is WAIT, with the timeout counter cleared.
- WAIT:
  - done_encrypt=1: capture C into the result register and go to SEND.
  - Otherwise the timeout counter increments.
  - If the counter equals TIMEOUT-1 and done_encrypt=0: go to ERR.
  - If done_encrypt arrives on that same cycle, the capture wins.
- Operand stability:
  - base, exponent and modulus hold stable from START through the end of SEND.
  - They change only on byte acceptance in LOAD.
- SEND:
  - out_valid=1; out_data is result[W-1:W-8].
  - On each handshake, shift the result left by 8 and increment the byte counter.
  - out_valid may not drop without a handshake.
  - After the NB-th handshake, go to LOAD on the next cycle with out_valid=0.
  - out_ready held low stalls indefinitely with out_data stable.
- ERR:
  - Lasts one cycle; sets err=1 and returns to LOAD.
  - err stays high until the next frame's byte 0 is accepted.
- Spurious inputs:
  - done_encrypt outside WAIT is ignored, with no capture and no state change.
  - in_valid outside LOAD is ignored because in_ready=0.
- busy=1 exactly in START, WAIT and SEND.
- No arithmetic beyond shifts, counters and a W-bit zero compare.

Test Plan:
- Frame base=4, exponent=13, modulus=497 (24 bytes, contiguous):
  - done pulses one cycle, one cycle after byte 23.
  - Engine model returns C=445 after 20 cycles.
  - out bytes are 00 00 00 00 00 00 01 BD; err=0; busy drops after the last handshake.
- Same frame with in_valid toggled every other cycle and out_ready low for 5 cycles mid-SEND:
  - Identical operands and output bytes.
  - out_data stays stable while stalled.
- Modulus all-zero:
  - No done pulse; err=1 one cycle after byte 23.
  - err clears on byte 0 of the next valid frame, which then completes normally.
- TIMEOUT=16 with the engine never responding:
  - err rises exactly 16 cycles after the done cycle; no out_valid.
  - Repeat with done_encrypt arriving at the 16th WAIT cycle: capture occurs, no err.
- done_encrypt pulsed during LOAD and during SEND:
  - Ignored; result bytes unchanged.
- rst asserted asynchronously mid-WAIT and mid-SEND:
  - Outputs zero immediately and in_ready=1.
  - A subsequent full frame completes correctly.
